// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry valid/ready holding buffer.
// Drops completed bytes with an overrun pulse when the buffer is still full.
module uart_rx #(
   parameter int unsigned CLOCK_HZ  = 10,
   parameter int unsigned BAUD_RATE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_error,
   output logic       overrun
);

   localparam logic [31:0] CPB       = 32'(CLOCK_HZ / BAUD_RATE);
   localparam logic [31:0] HALF_LAST = (CPB / 32'd2) - 32'd1;
   localparam logic [31:0] FULL_LAST = CPB - 32'd1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e      state_q;
   logic [1:0]  sync_q;
   logic [31:0] cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shift_q;
   logic [7:0]  shift_d;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        frame_error_q;
   logic        overrun_q;
   logic        rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      shift_d            = shift_q;
      shift_d[bit_idx_q] = rx_s;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         sync_q        <= 2'b11;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         data_q        <= 8'h00;
         valid_q       <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], rx};
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         cnt_q         <= cnt_q + 32'd1;
         // NOTE: these are defaults; a later non-blocking assignment to the same
         // register in this block wins, so the FSM below overrides them freely.
         if (valid_q && ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt_q == FULL_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= shift_d;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            STOP: begin
               if (cnt_q == FULL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  if (!rx_s) begin
                     frame_error_q <= 1'b1;
                  end else if (!valid_q || ready) begin
                     // A consume in this same cycle frees the buffer for the new byte.
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;

endmodule
